complex_dot_feeder: RTL and testbench

//  Operand transmitter for the complex dot-product engine. It accepts one complex

---
 rtl/complex_dot_feeder.sv | 86 ++++++++
 tb/tb_complex_dot_feeder.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/complex_dot_feeder.sv
// Double-banked operand packer: collects SIZE complex terms per vector and hands the vector to the dot-product engine.
// Optional macro CMM_FEED_CONJ_EN: conj_i flips the sign of b2 on accepted beats.
module complex_dot_feeder #(
  parameter int SIZE = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [3:0][63:0]           in_term_i,
  input  logic                       in_last_i,
  input  logic                       conj_i,
  input  logic                       flush_i,
  output logic [SIZE*4-1:0][63:0]    operands_o,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic                       busy_o
);

  localparam int CW = $clog2(SIZE);

  logic [SIZE*4-1:0][63:0] r_bank [2];
  logic                    r_fill_ptr;
  logic                    r_send_ptr;
  logic [1:0]              r_full_cnt;
  logic [CW-1:0]           r_cnt;

  logic                    w_accept;
  logic                    w_close;
  logic                    w_handoff;
  logic [3:0][63:0]        w_term;

  assign in_ready_o  = (r_full_cnt < 2'd2);
  assign out_valid_o = (r_full_cnt != 2'd0);
  assign busy_o      = (r_full_cnt != 2'd0) | (r_cnt != '0);
  assign operands_o  = r_bank[r_send_ptr];

  assign w_accept  = in_valid_i & in_ready_o;
  assign w_close   = w_accept & (in_last_i | (r_cnt == CW'(SIZE - 1)));
  assign w_handoff = out_valid_o & out_ready_i;

  always_comb begin
    w_term = in_term_i;
`ifdef CMM_FEED_CONJ_EN
    w_term[3][63] = in_term_i[3][63] ^ conj_i;
`endif
  end

`ifndef CMM_FEED_CONJ_EN
  logic w_conj_unused;
  assign w_conj_unused = conj_i;
`endif

  // A bank is zeroed as it is released by a handoff, so whichever bank becomes
  // the fill bank at a close is already clear and a pending vector is never disturbed.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      r_bank[0]  <= '0;
      r_bank[1]  <= '0;
      r_fill_ptr <= 1'b0;
      r_send_ptr <= 1'b0;
      r_full_cnt <= 2'd0;
      r_cnt      <= '0;
    end else begin
      if (w_accept) begin
        r_bank[r_fill_ptr][{r_cnt, 2'b00} +: 4] <= w_term;
      end
      if (w_close) begin
        r_cnt      <= '0;
        r_fill_ptr <= ~r_fill_ptr;
      end else if (w_accept) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_handoff) begin
        r_bank[r_send_ptr] <= '0;
        r_send_ptr         <= ~r_send_ptr;
      end
      case ({w_close, w_handoff})
        2'b10:   r_full_cnt <= r_full_cnt + 2'd1;
        2'b01:   r_full_cnt <= r_full_cnt - 2'd1;
        default: r_full_cnt <= r_full_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_complex_dot_feeder.sv
// Self-checking bench for complex_dot_feeder: directed table, corner sequences and random traffic vs a queue-based model.
module tb_complex_dot_feeder;

  localparam int SIZE = 16;
  localparam int NW   = SIZE * 4;

  typedef logic [NW-1:0][63:0] vec_t;

  logic             clk_i = 1'b0;
  logic             rst_i = 1'b1;
  logic             in_valid_i = 1'b0;
  logic             in_ready_o;
  logic [3:0][63:0] in_term_i = '0;
  logic             in_last_i = 1'b0;
  logic             conj_i = 1'b0;
  logic             flush_i = 1'b0;
  vec_t             operands_o;
  logic             out_valid_o;
  logic             out_ready_i = 1'b0;
  logic             busy_o;

  complex_dot_feeder #(.SIZE(SIZE)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_term_i   (in_term_i),
    .in_last_i   (in_last_i),
    .conj_i      (conj_i),
    .flush_i     (flush_i),
    .operands_o  (operands_o),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .busy_o      (busy_o)
  );

  always #5 clk_i = ~clk_i;

  int n_vec  = 0;
  int n_miss = 0;

  // Reference model: a FIFO of completed vectors (depth 2) and one partial vector.
  vec_t m_q[$];
  vec_t m_part = '0;
  int   m_cnt  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_vec(input string name, input vec_t act, input vec_t exp);
    int idx;
    idx = 0;
    for (int i = NW - 1; i >= 0; i--)
      if (act[i] !== exp[i]) idx = i;
    chk($sformatf("%s[w%0d]", name, idx), act[idx], exp[idx]);
  endtask

  task automatic model_edge(input logic v, input logic last, input logic cj, input logic fl,
                            input logic rs, input logic ordy, input logic [3:0][63:0] term);
    logic acc, hand;
    logic [3:0][63:0] t;
    if (rs || fl) begin
      m_q.delete();
      m_part = '0;
      m_cnt  = 0;
    end else begin
      acc  = v && (m_q.size() < 2);
      hand = (m_q.size() != 0) && ordy;
      if (hand) void'(m_q.pop_front());
      if (acc) begin
        t = term;
`ifdef CMM_FEED_CONJ_EN
        if (cj) t[3][63] = ~t[3][63];
`endif
        m_part[m_cnt*4 +: 4] = t;
        if (last || m_cnt == SIZE - 1) begin
          m_q.push_back(m_part);
          m_part = '0;
          m_cnt  = 0;
        end else begin
          m_cnt++;
        end
      end
    end
  endtask

  task automatic check_model();
    chk("in_ready", 64'(in_ready_o), 64'(m_q.size() < 2));
    chk("out_valid", 64'(out_valid_o), 64'(m_q.size() != 0));
    chk("busy", 64'(busy_o), 64'((m_q.size() != 0) || (m_cnt != 0)));
    if (m_q.size() != 0) chk_vec("operands", operands_o, m_q[0]);
  endtask

  task automatic cycle(input logic v, input logic last, input logic cj, input logic fl,
                       input logic rs, input logic ordy, input logic [3:0][63:0] term);
    in_valid_i  = v;
    in_last_i   = last;
    conj_i      = cj;
    flush_i     = fl;
    rst_i       = rs;
    out_ready_i = ordy;
    in_term_i   = term;
    @(posedge clk_i);
    model_edge(v, last, cj, fl, rs, ordy, term);
    #1;
    check_model();
  endtask

  function automatic logic [3:0][63:0] rnd_term();
    logic [3:0][63:0] t;
    for (int j = 0; j < 4; j++) t[j] = {$urandom, $urandom};
    return t;
  endfunction

  function automatic logic [3:0][63:0] seq_term(input int k);
    logic [3:0][63:0] t;
    for (int j = 0; j < 4; j++) t[j] = 64'(4 * k + j);
    return t;
  endfunction

  typedef struct {
    logic v, last, fl, rs, ordy;
    logic e_rdy, e_val, e_busy;
  } row_t;

  row_t tbl[10];
  vec_t snap;
  logic [3:0][63:0] cterm;

  initial begin
    //            v  last fl rs ordy  rdy val busy   (expected after the edge)
    tbl[0] = '{1'b0,1'b0,1'b0,1'b1,1'b0, 1'b1,1'b0,1'b0};
    tbl[1] = '{1'b1,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b1};
    tbl[2] = '{1'b1,1'b1,1'b0,1'b0,1'b0, 1'b1,1'b1,1'b1};
    tbl[3] = '{1'b1,1'b1,1'b0,1'b0,1'b0, 1'b0,1'b1,1'b1};
    tbl[4] = '{1'b1,1'b0,1'b0,1'b0,1'b1, 1'b1,1'b1,1'b1};
    tbl[5] = '{1'b0,1'b0,1'b0,1'b0,1'b1, 1'b1,1'b0,1'b0};
    tbl[6] = '{1'b1,1'b0,1'b1,1'b0,1'b0, 1'b1,1'b0,1'b0};
    tbl[7] = '{1'b1,1'b1,1'b0,1'b0,1'b0, 1'b1,1'b1,1'b1};
    tbl[8] = '{1'b1,1'b1,1'b0,1'b0,1'b1, 1'b1,1'b1,1'b1};
    tbl[9] = '{1'b0,1'b0,1'b0,1'b0,1'b1, 1'b1,1'b0,1'b0};

    // Reset state
    cycle(0, 0, 0, 0, 1, 0, '0);
    cycle(0, 0, 0, 0, 1, 0, '0);
    chk_vec("reset_operands", operands_o, '0);
    chk("reset_ready", 64'(in_ready_o), 64'd1);

    // Directed table
    for (int i = 0; i < 10; i++) begin
      cycle(tbl[i].v, tbl[i].last, 1'b0, tbl[i].fl, tbl[i].rs, tbl[i].ordy, rnd_term());
      chk($sformatf("tbl%0d_ready", i), 64'(in_ready_o), 64'(tbl[i].e_rdy));
      chk($sformatf("tbl%0d_valid", i), 64'(out_valid_o), 64'(tbl[i].e_val));
      chk($sformatf("tbl%0d_busy", i), 64'(busy_o), 64'(tbl[i].e_busy));
    end

    // Full fill: word i == i, valid right after beat 15
    for (int k = 0; k < SIZE; k++) begin
      cycle(1, 0, 0, 0, 0, 1, seq_term(k));
      if (k == SIZE - 2) chk("fill_valid_early", 64'(out_valid_o), 64'd0);
    end
    chk("fill_valid", 64'(out_valid_o), 64'd1);
    for (int i = 0; i < NW; i++) snap[i] = 64'(i);
    chk_vec("fill_words", operands_o, snap);
    cycle(0, 0, 0, 0, 0, 1, '0);
    chk("fill_busy_after", 64'(busy_o), 64'd0);

    // Early close after 3 beats: words 12.. are zero
    for (int k = 0; k < 3; k++) cycle(1, k == 2, 0, 0, 0, 0, rnd_term());
    chk("early_valid", 64'(out_valid_o), 64'd1);
    snap = operands_o;
    for (int i = 0; i < 12; i++) snap[i] = '0;
    chk_vec("early_pad", snap, '0);
    cycle(0, 0, 0, 0, 0, 1, '0);

    // Backpressure: 2*SIZE beats fill both banks, extra beat stalls
    for (int k = 0; k < 2 * SIZE; k++) cycle(1, 0, 0, 0, 0, 0, rnd_term());
    chk("bp_ready_low", 64'(in_ready_o), 64'd0);
    snap = operands_o;
    cycle(1, 0, 0, 0, 0, 0, rnd_term());
    cycle(1, 0, 0, 0, 0, 0, rnd_term());
    chk_vec("bp_stable", operands_o, snap);
    cycle(0, 0, 0, 0, 0, 1, '0);
    chk("bp_ready_back", 64'(in_ready_o), 64'd1);
    cycle(0, 0, 0, 0, 0, 1, '0);
    chk("bp_drained", 64'(out_valid_o), 64'd0);

    // Flush, then reset, mid-fill with a valid beat in the same cycle
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 5; k++) cycle(1, 0, 0, 0, 0, 0, rnd_term());
      cycle(1, 0, 0, r == 0, r == 1, 0, rnd_term());
      chk($sformatf("clr%0d_busy", r), 64'(busy_o), 64'd0);
      chk($sformatf("clr%0d_valid", r), 64'(out_valid_o), 64'd0);
      for (int k = 0; k < SIZE; k++) cycle(1, 0, 0, 0, 0, 0, seq_term(k));
      for (int i = 0; i < NW; i++) snap[i] = 64'(i);
      chk_vec($sformatf("clr%0d_vector", r), operands_o, snap);
      cycle(0, 0, 0, 0, 0, 1, '0);
    end

    // Conjugate flag on b2
    cterm = '0;
    cterm[3] = 64'h3FF0000000000000;
    cycle(1, 1, 1, 0, 0, 0, cterm);
`ifdef CMM_FEED_CONJ_EN
    chk("conj_b2", operands_o[3], 64'hBFF0000000000000);
`else
    chk("conj_b2", operands_o[3], 64'h3FF0000000000000);
`endif
    cycle(0, 0, 0, 0, 0, 1, '0);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      cycle(($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0), $urandom_range(0, 1),
            ($urandom_range(0, 199) == 0), 1'b0, ($urandom_range(0, 2) != 0), rnd_term());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
